multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the register-file, PC, instruction-register and data-memory enables. In EXEC it drives the 3-bit `branch` code consumed by `branch_condition`, which resolves PC source from the ALU flags. It also implements the instruction- and data-memory ready handshakes, traps on illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32, width of `instret` counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  IR[6:0], valid from DECODE onward.
- `funct3`  in  3  IR[14:12].
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `imem_req`  out  1  fetch request.
- `ir_we`  out  1  latch instruction word and its PC (`old_pc`).
- `pc_we`  out  1  PC update using `branch_condition` result.
- `branch`  out  3  code to `branch_condition`.
- `alu_unsigned`  out  1  unsigned compare (BLTU/BGEU).
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  store when 1, load when 0.
- `reg_we`  out  1  register-file write.
- `wb_sel`  out  2  00 ALU, 01 load data, 10 `old_pc`+4.
- `illegal`  out  1  sticky trap flag.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: `imem_req`=1 until `imem_ready`. On the `imem_ready` cycle, `ir_we`=1 and next state is DECODE.
- DECODE: one cycle, no outputs. Illegal opcode goes to TRAP. Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- EXEC: `pc_we`=1 for exactly one cycle for every legal instruction.
- `branch` in EXEC:
  - BRANCH: funct3 000→000, 001→001, 100/110→010, 101/111→011. `alu_unsigned`=1 for funct3 11x.
  - JAL→100, JALR→101, all others→110 (PC+4).
  - BRANCH with funct3 010/011 is illegal: go to TRAP from DECODE.
- Next state after EXEC:
  - LOAD/STORE→MEM.
  - BRANCH, MISC-MEM, SYSTEM→FETCH (treated as NOP, retire in EXEC).
  - All others→WB.
- MEM: `dmem_req`=1 and `dmem_we`=(STORE) until `dmem_ready`. Then STORE retires and goes to FETCH; LOAD goes to WB.
- WB: `reg_we`=1 for one cycle. `wb_sel`=01 for LOAD, 10 for JAL/JALR, else 00. Retires, then FETCH.
- TRAP: absorbing until `rst`. `illegal`=1 and every enable is 0.
- `retired` pulses on the retiring cycle; `instret` increments by 1 on that edge and wraps at 2^CNT_W−1 → 0.

## Timing
- Reset (async, asserts immediately): state FETCH; `illegal`=0, `instret`=0, every enable/pulse 0, `branch`=110, `wb_sel`=00, `alu_unsigned`=0. `imem_req` rises one cycle after `rst` deasserts.
- `branch` is 110 in every state except EXEC.
- Outputs are a Moore decode of state plus latched opcode/funct3; no input-to-output combinational path except `ir_we`/`dmem` completion qualified by ready.
- Cycle counts with zero-wait memory:
  - BRANCH/NOP: 3.
  - ALU/LUI/AUIPC/JAL/JALR/STORE: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- A ready input held high outside FETCH/MEM is ignored.
- Reset mid-instruction aborts with no further `reg_we`/`dmem_req`. An in-flight memory request is dropped; the memory side handles its own reset.

## Structure
- Package `rv32i_ctrl_pkg`: opcode constants, 3-bit branch codes (BEQ 000, BNE 001, BLT 010, BGE 011, JAL 100, JALR 101, SEQ 110), `wb_sel` codes, state encoding.
- One combinational sub-module `ctrl_decode`: opcode/funct3 → {legal, class, branch code, alu_unsigned, wb_sel}. The FSM and counter live in the top.

## Test plan
- ADD (0110011), zero-wait: FETCH→DECODE→EXEC→WB. `pc_we` in cycle 3 with `branch`=110, `reg_we` in cycle 4 with `wb_sel`=00, `instret`=1.
- BLTU (funct3 110): `branch`=010 and `alu_unsigned`=1 in EXEC. No `reg_we`; back to FETCH after 3 cycles.
- LOAD with `dmem_ready` delayed 2 cycles: `dmem_req` high 3 cycles with `dmem_we`=0, then WB with `wb_sel`=01. Total 7 cycles.
- JALR: `branch`=101 in EXEC, WB with `wb_sel`=10. JAL gives `branch`=100.
- Opcode 0000000: TRAP after DECODE. `illegal`=1 and stays; no `pc_we`/`reg_we`; `instret` unchanged until `rst`.
- `rst` asserted during MEM of a STORE: `dmem_req` drops in the same cycle, state FETCH, `instret`=0. With `CNT_W`=4, 16 retirements wrap `instret` to 0.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control path: opcodes, branch
// codes handed to branch_condition, write-back selects and FSM encodings.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_JAL  = 3'b100;
  localparam logic [2:0] BR_JALR = 3'b101;
  localparam logic [2:0] BR_SEQ  = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Instruction class decides the path taken after EXEC.
  typedef enum logic [1:0] {
    CLS_NOP   = 2'd0,  // branches, fences, system: retire in EXEC
    CLS_WB    = 2'd1,  // ALU, LUI, AUIPC, JAL, JALR: write back
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct3 to legality, class,
// branch code, unsigned-compare flag and write-back select.
module ctrl_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic       legal,
  output logic [1:0] cls,
  output logic [2:0] br,
  output logic       uns,
  output logic [1:0] wbsel
);

  // Opcode table; anything not listed is illegal.
  always_comb begin
    legal = 1'b1;
    cls   = CLS_NOP;
    br    = BR_SEQ;
    uns   = 1'b0;
    wbsel = WB_ALU;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP: cls = CLS_WB;
      OP_JAL: begin
        cls   = CLS_WB;
        br    = BR_JAL;
        wbsel = WB_PC4;
      end
      OP_JALR: begin
        cls   = CLS_WB;
        br    = BR_JALR;
        wbsel = WB_PC4;
      end
      OP_BRANCH: begin
        cls = CLS_NOP;
        uns = funct3[2] & funct3[1];
        case (funct3)
          3'b000:         br = BR_BEQ;
          3'b001:         br = BR_BNE;
          3'b100, 3'b110: br = BR_BLT;
          3'b101, 3'b111: br = BR_BGE;
          default:        legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        cls   = CLS_LOAD;
        wbsel = WB_MEM;
      end
      OP_STORE:           cls = CLS_STORE;
      OP_MISC, OP_SYSTEM: cls = CLS_NOP;
      default:            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with
// memory ready handshakes, illegal-opcode trap and retired-instruction count.
module multicycle_control
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [2:0]       branch,
  output logic             alu_unsigned,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] instret
);

  state_t     state, state_nxt;
  logic       run;
  logic       dec_legal;
  logic [1:0] dec_cls;
  logic [2:0] dec_br;
  logic       dec_uns;
  logic [1:0] dec_wbsel;
  cls_t       cls_q;
  logic [2:0] br_q;
  logic       uns_q;
  logic [1:0] wbsel_q;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .legal  (dec_legal),
    .cls    (dec_cls),
    .br     (dec_br),
    .uns    (dec_uns),
    .wbsel  (dec_wbsel)
  );

  // State register; run holds off the first fetch for one cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Decoded fields captured in DECODE and held for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      cls_q   <= cls_t'(dec_cls);
      br_q    <= dec_br;
      uns_q   <= dec_uns;
      wbsel_q <= dec_wbsel;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (retired) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; only ir_we and memory completion see ready.
  always_comb begin
    state_nxt    = state;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    branch       = BR_SEQ;
    alu_unsigned = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = 1'b0;
    retired      = 1'b0;
    case (state)
      ST_FETCH: begin
        if (run) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we     = 1'b1;
            state_nxt = ST_DECODE;
          end
        end
      end
      ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        pc_we        = 1'b1;
        branch       = br_q;
        alu_unsigned = uns_q;
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          CLS_NOP: begin
            retired   = 1'b1;
            state_nxt = ST_FETCH;
          end
          default: state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            retired   = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        wb_sel    = wbsel_q;
        retired   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control (instret width 4).
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          imem_ready, dmem_ready;
  logic          imem_req, ir_we, pc_we, alu_unsigned;
  logic          dmem_req, dmem_we, reg_we, illegal, retired;
  logic [2:0]    branch;
  logic [1:0]    wb_sel;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .branch       (branch),
    .alu_unsigned (alu_unsigned),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .retired      (retired),
    .instret      (instret)
  );

  typedef struct {
    logic [2:0] br;
    logic       uns;
    logic       wb;
    logic [1:0] wbs;
    logic       mem;
    logic       st;
    int         dw;
    int         cycles;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  int         total = 0;
  int         bad = 0;
  int         model_cnt = 0;
  bit         mon_en = 0;
  logic [6:0] ops [11];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference behaviour straight from the instruction rules.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input int iw, input int dw);
    exp_t e;
    e.br = 3'b110; e.uns = 1'b0; e.wb = 1'b0; e.wbs = 2'b00;
    e.mem = 1'b0; e.st = 1'b0; e.dw = 0;
    case (op)
      7'b1100011: begin
        e.br  = {1'b0, f3[2], f3[0]};
        e.uns = (f3[2:1] == 2'b11);
      end
      7'b1101111: begin e.br = 3'b100; e.wb = 1'b1; e.wbs = 2'b10; end
      7'b1100111: begin e.br = 3'b101; e.wb = 1'b1; e.wbs = 2'b10; end
      7'b0000011: begin e.mem = 1'b1; e.wb = 1'b1; e.wbs = 2'b01; e.dw = dw; end
      7'b0100011: begin e.mem = 1'b1; e.st = 1'b1; e.dw = dw; end
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: e.wb = 1'b1;
      default: ;
    endcase
    e.cycles = 3 + iw + (e.mem ? e.dw + 1 : 0) + (e.wb ? 1 : 0);
    return e;
  endfunction

  task automatic wait_imem(output bit ok);
    int n = 0;
    while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
    ok = imem_req;
    if (!ok) chk("imem_req_timeout", 0, 1);
  endtask

  task automatic give_instr(input logic [6:0] op, input logic [2:0] f3, input int iw);
    repeat (iw) begin @(posedge clk); #1; end
    opcode = op; funct3 = f3; imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int iw, input int dw);
    exp_t e;
    bit   ok;
    int   n;
    e = model(op, f3, iw, dw);
    wait_imem(ok);
    if (!ok) return;
    exp_q.push_back(e);
    give_instr(op, f3, iw);
    if (e.mem) begin
      n = 0;
      while (!dmem_req && n < 20) begin @(posedge clk); #1; n++; end
      if (!dmem_req) begin
        chk("dmem_req_timeout", 0, 1);
        return;
      end
      repeat (e.dw) begin @(posedge clk); #1; end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
  endtask

  task automatic rand_instr();
    logic [6:0] op;
    logic [2:0] f3;
    op = ops[$urandom_range(0, 10)];
    f3 = 3'($urandom_range(0, 7));
    if (op == 7'b1100011 && f3[2:1] == 2'b01) f3[1] = 1'b0;
    do_instr(op, f3, $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: follows each instruction from its first FETCH cycle to retirement.
  int cyc, npc, nreg, ndm;
  bit busy = 0;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      busy = 0;
    end else begin
      if (!busy && imem_req && exp_q.size() > 0) begin
        busy = 1; cyc = 0; npc = 0; nreg = 0; ndm = 0;
      end
      if (busy) begin
        me = exp_q[0];
        cyc++;
        if (pc_we) begin
          npc++;
          chk("branch", branch, me.br);
          chk("alu_unsigned", alu_unsigned, me.uns);
        end else begin
          chk("branch_idle", branch, 3'b110);
        end
        if (reg_we) begin
          nreg++;
          chk("wb_sel", wb_sel, me.wbs);
        end
        if (dmem_req) begin
          ndm++;
          chk("dmem_we", dmem_we, me.st);
        end
        if (retired) begin
          chk("cycles", cyc, me.cycles);
          chk("pc_we_count", npc, 1);
          chk("reg_we_count", nreg, me.wb ? 1 : 0);
          chk("dmem_req_cycles", ndm, me.mem ? me.dw + 1 : 0);
          chk("instret_before", instret, model_cnt % (1 << CW));
          chk("illegal_run", illegal, 0);
          model_cnt++;
          void'(exp_q.pop_front());
          busy = 0;
        end else if (cyc > 60) begin
          chk("retire_timeout", 0, 1);
          void'(exp_q.pop_front());
          busy = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [CW-1:0] saved;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    rst = 1'b1; opcode = '0; funct3 = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #3;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_enables", {ir_we, pc_we, dmem_req, dmem_we, reg_we, retired}, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);
    chk("rst_branch", branch, 3'b110);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_alu_unsigned", alu_unsigned, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("imem_req_after_rst", imem_req, 0);
    @(posedge clk); #1;
    chk("imem_req_rises", imem_req, 1);

    // Directed instructions from the test plan, then random ones: 16 total.
    mon_en = 1;
    do_instr(7'b0110011, 3'b000, 0, 0);  // ADD
    do_instr(7'b1100011, 3'b110, 0, 0);  // BLTU
    do_instr(7'b0000011, 3'b010, 0, 2);  // LW, two wait cycles
    do_instr(7'b1100111, 3'b000, 0, 0);  // JALR
    do_instr(7'b1101111, 3'b000, 1, 0);  // JAL, one fetch wait
    do_instr(7'b0100011, 3'b010, 0, 0);  // SW
    repeat (10) rand_instr();
    drain();
    chk("instret_wrap", instret, 0);

    repeat (40) rand_instr();
    drain();
    chk("instret_final", instret, model_cnt % (1 << CW));

    // Reset while a store waits in MEM.
    mon_en = 0;
    wait_imem(ok);
    give_instr(7'b0100011, 3'b010, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("store_dmem_req", dmem_req, 1);
    chk("store_dmem_we", dmem_we, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mem_dmem_req", dmem_req, 0);
    chk("rst_mem_instret", instret, 0);
    chk("rst_mem_branch", branch, 3'b110);
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 0; exp_q.delete(); mon_en = 1;
    do_instr(7'b0110011, 3'b000, 0, 0);
    drain();
    chk("instret_after_rst", instret, 1);

    // Illegal opcode: trap is absorbing and ignores ready inputs.
    mon_en = 0;
    wait_imem(ok);
    saved = instret;
    give_instr(7'b0000000, 3'b000, 0);
    chk("illegal_in_decode", illegal, 0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("trap_illegal", illegal, 1);
      chk("trap_enables", {pc_we, reg_we, dmem_req, imem_req, ir_we, retired}, 0);
      chk("trap_instret", instret, saved);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    #1 chk("trap_cleared", illegal, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Branch with reserved funct3 also traps.
    wait_imem(ok);
    give_instr(7'b1100011, 3'b011, 0);
    @(posedge clk); #1;
    chk("bad_branch_illegal", illegal, 1);
    chk("bad_branch_pc_we", pc_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
